// File: rtl/div_pkg.sv
// Shared types and constants for the RV32IM divide/remainder sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted partial remainder needs one extra bit: it can reach
  // 2*divisor-1, and the trial subtraction's sign lands in the top bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift {rem, quo} left, subtract, keep the difference only if non-negative.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller for the EX stage. Works on
// magnitudes for 32 restoring steps, then fixes the sign of the selected
// result. Divide-by-zero and INT_MIN/-1 finish without iterating.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] OPERAND_A,
  input  logic [WIDTH-1:0] OPERAND_B,
  input  logic             FLUSH,
  output logic             STALL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  logic             accept;
  logic             is_signed;
  logic             is_rem;
  logic             div_zero;
  logic             overflow;

  // Two's-complement magnitude of a signed operand; INT_MIN maps to 2^31,
  // which is still exact when read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  // Conditional negation used by the sign-fix step.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? WIDTH'(-x) : x;
  endfunction

  // Decode the operation and the cases that need no iteration.
  always_comb begin
    is_signed = (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
    is_rem    = (FUNCT3 == F3_REM) || (FUNCT3 == F3_REMU);
    div_zero  = (OPERAND_B == '0);
    overflow  = is_signed && (OPERAND_A == INT_MIN) && (OPERAND_B == ALL_ONES);
    accept    = (state == ST_IDLE) && START && FUNCT3[2] && !FLUSH;
    STALL     = accept || (state == ST_CALC) || (state == ST_FIX);
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sequencer FSM with registered DONE/BUSY/RESULT; operand registers are
  // data only and are loaded on accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      RESULT <= '0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
    end else if (FLUSH) begin
      state <= ST_IDLE;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (accept) begin
            is_rem_q  <= is_rem;
            neg_quo_q <= is_signed && (OPERAND_A[WIDTH-1] ^ OPERAND_B[WIDTH-1]);
            neg_rem_q <= is_signed && OPERAND_A[WIDTH-1];
            quo_q     <= is_signed ? abs_val(OPERAND_A) : OPERAND_A;
            dvs_q     <= is_signed ? abs_val(OPERAND_B) : OPERAND_B;
            rem_q     <= '0;
            cnt       <= 5'd0;
            if (div_zero) begin
              RESULT <= is_rem ? OPERAND_A : ALL_ONES;
              state  <= ST_DONE;
              DONE   <= 1'b1;
            end else if (overflow) begin
              RESULT <= is_rem ? '0 : INT_MIN;
              state  <= ST_DONE;
              DONE   <= 1'b1;
            end else begin
              state <= ST_CALC;
              BUSY  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          RESULT <= is_rem_q ? neg_if(rem_q, neg_rem_q) : neg_if(quo_q, neg_quo_q);
          state  <= ST_DONE;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed corner cases plus randomized ops
// compared against an arithmetic reference of the RISC-V M-extension rules.
module tb_div_sequencer;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        FLUSH;
  logic        STALL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_result = '0;

  div_sequencer #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .FUNCT3    (FUNCT3),
    .OPERAND_A (OPERAND_A),
    .OPERAND_B (OPERAND_B),
    .FLUSH     (FLUSH),
    .STALL     (STALL),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge. Issues one op, follows it to DONE
  // and checks latency, stall count and result.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit keep);
    int          cyc;
    int          stall_cnt;
    bit          got_done;
    bit          special;
    logic [31:0] exp;
    exp       = ref_div(f3, a, b);
    special   = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    FUNCT3    = f3;
    OPERAND_A = a;
    OPERAND_B = b;
    START     = 1'b1;
    #1;
    check("stall_on_start", STALL, 1'b1);
    stall_cnt = 1;
    cyc       = 0;
    got_done  = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge CLK);
      cyc++;
      if (DONE) begin
        got_done = 1'b1;
      end else begin
        if (STALL) stall_cnt++;
        OPERAND_A = $urandom;
        OPERAND_B = $urandom;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", cyc, special ? 32'd1 : 32'd34);
    check("stall_cycles", stall_cnt, special ? 32'd1 : 32'd34);
    check("stall_in_done", STALL, 1'b0);
    check("result", RESULT, exp);
    last_result = exp;
    if (!keep) START = 1'b0;
    @(negedge CLK);
    check("done_one_cycle", DONE, 1'b0);
    check("busy_after_done", BUSY, 1'b0);
    check("result_held", RESULT, exp);
  endtask

  initial begin
    bit          seen;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    RESET     = 1'b1;
    START     = 1'b0;
    FLUSH     = 1'b0;
    FUNCT3    = 3'b000;
    OPERAND_A = '0;
    OPERAND_B = '0;
    repeat (3) @(negedge CLK);
    check("rst_result", RESULT, 32'h0);
    check("rst_done", DONE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_stall", STALL, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);

    // Directed arithmetic and special cases
    run_op(3'b101, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", RESULT, 32'd14);
    run_op(3'b111, 32'd100, 32'd7, 1'b0);
    check("remu_100_7", RESULT, 32'd2);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("rem_m7_2", RESULT, 32'hFFFF_FFFF);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check("rem_7_m2", RESULT, 32'd1);
    run_op(3'b100, 32'd5, 32'd0, 1'b0);
    check("div_by_zero", RESULT, 32'hFFFF_FFFF);
    run_op(3'b111, 32'd5, 32'd0, 1'b0);
    check("remu_by_zero", RESULT, 32'd5);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_overflow", RESULT, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("rem_overflow", RESULT, 32'h0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2", RESULT, 32'hFFFF_FFFD);

    // Flush at CALC count 10
    FUNCT3    = 3'b101;
    OPERAND_A = 32'd1000;
    OPERAND_B = 32'd3;
    START     = 1'b1;
    repeat (11) @(negedge CLK);
    check("busy_before_flush", BUSY, 1'b1);
    FLUSH = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy", BUSY, 1'b0);
    check("flush_stall", STALL, 1'b0);
    check("flush_done", DONE, 1'b0);
    check("flush_result", RESULT, last_result);
    seen = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (DONE || BUSY) seen = 1'b1;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    run_op(3'b100, 32'd1000, 32'd7, 1'b0);

    // Reset mid-CALC with START held
    FUNCT3    = 3'b100;
    OPERAND_A = 32'd12345;
    OPERAND_B = 32'd17;
    START     = 1'b1;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_result", RESULT, 32'h0);
    check("midrst_done", DONE, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (DONE || BUSY) seen = 1'b1;
    end
    check("rst_held_no_accept", 32'(seen), 32'd0);
    START = 1'b0;
    RESET = 1'b0;
    #1;
    check("rst_release_stall", STALL, 1'b0);
    @(negedge CLK);
    last_result = '0;

    // Back-to-back DIVU; START stays high through the DONE cycle
    run_op(3'b101, 32'd100, 32'd7, 1'b1);
    check("b2b_first", RESULT, 32'd14);
    run_op(3'b101, 32'd9, 32'd3, 1'b0);
    check("b2b_second", RESULT, 32'd3);

    // Non-divide funct3 is ignored
    FUNCT3 = 3'b000;
    START  = 1'b1;
    #1;
    check("nondiv_stall", STALL, 1'b0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (DONE || BUSY || STALL) seen = 1'b1;
    end
    check("nondiv_ignored", 32'(seen), 32'd0);
    START = 1'b0;
    @(negedge CLK);

    // Randomized ops
    repeat (40) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, a, b, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the RV32IM M-extension divide/remainder operations (DIV, DIVU, REM, REMU) in the EX stage. It captures operands on a start request and runs a radix-2 restoring division over 32 iterations. It stalls the pipeline while busy, then presents the sign-corrected quotient or remainder for one cycle. Divide-by-zero and signed-overflow cases are resolved in a single cycle without iterating.

## Interface
- WIDTH, 32, operand/result width; only 32 is required to work
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high; sampled on rising edge of CLK
- START  input  1  EX-stage instruction is a divide/remainder op; level, held by stalled pipeline
- FUNCT3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; FUNCT3[2]=0 means not a divide op, START ignored
- OPERAND_A  input  WIDTH  dividend, after forwarding muxes
- OPERAND_B  input  WIDTH  divisor, after forwarding muxes
- FLUSH  input  1  branch/jump flush of EX; aborts any operation
- STALL  output  1  hold IF/ID/EX pipeline registers
- BUSY  output  1  state is CALC or FIX
- DONE  output  1  one-cycle pulse, RESULT valid
- RESULT  output  WIDTH  quotient or remainder; held until the next accepted START

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept condition: IDLE & START & FUNCT3[2] & ~FLUSH.
- IDLE, on accept:
  - Latch the op, the sign flags and |A|, |B|. Magnitudes are used only for signed ops (FUNCT3[0]=0).
  - Clear the remainder register and count.
  - B==0: RESULT = all-ones for a quotient op, or A for a remainder op. Go to DONE.
  - Signed op with A==0x80000000 and B==0xFFFFFFFF: RESULT = 0x80000000 for DIV, 0 for REM. Go to DONE.
  - Otherwise go to CALC.
- CALC:
  - One restoring step per cycle: shift {rem, quo} left 1; trial = rem - divisor; if non-negative, rem = trial and quo[0] = 1.
  - Count 0..31. After the step with count==31, go to FIX.
- FIX:
  - Quotient is negated if signed and sign(A) != sign(B).
  - Remainder is negated if signed and sign(A)=1.
  - Write RESULT from the quotient (FUNCT3[1]=0) or the remainder (FUNCT3[1]=1). Go to DONE.
- DONE: DONE=1 for this cycle. Go to IDLE unconditionally. START is ignored here, because the pipeline is advancing.
- FLUSH in any state: next state IDLE, DONE not asserted, RESULT unchanged.
- FLUSH together with RESET: RESET wins. Both give the same result.
- Operand inputs are ignored after acceptance, so changes to forwarding during CALC have no effect.

## Timing
- STALL = (IDLE & accept) | CALC | FIX. Combinational, so STALL is high in the same cycle START first appears.
- STALL is low in DONE, so the EX/MEM register captures RESULT at the end of the DONE cycle.
- Normal latency: accept at edge n; CALC spans edges n+1..n+32; FIX at edge n+33; DONE high between edges n+33 and n+34. That is 34 stall cycles.
- Special-case latency: accept at edge n, DONE high between edges n and n+1. STALL is high for 1 cycle.
- Back-to-back divides: the second START is seen in IDLE in the cycle after DONE and is accepted there. There is no lost cycle beyond that IDLE cycle.
- Reset values: state IDLE, count 0, RESULT 0, DONE 0, BUSY 0. STALL is 0 unless START is asserted in IDLE.
- Reset mid-operation: the operation is abandoned and no DONE is produced.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - FUNCT3 constants F3_DIV, F3_DIVU, F3_REM, F3_REMU;
  - the constants INT_MIN = 0x80000000 and ALL_ONES.
- Sub-module div_step: purely combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem and next quo. Instantiated once.
- div_sequencer holds the FSM, the 5-bit counter, the operand/sign registers, the sign-fix logic and the RESULT register.

## Test plan
- DIVU 100/7, START held: STALL high 34 cycles, DONE at the 34th cycle after accept, RESULT=14. REMU with the same operands gives RESULT=2.
- DIV -7/2 gives RESULT=0xFFFFFFFD (-3). REM -7/2 gives RESULT=0xFFFFFFFF (-1). REM 7/-2 gives RESULT=1.
- DIV 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM of the same gives 0. Each completes with DONE one cycle after accept.
- FLUSH asserted at CALC count 10: IDLE next cycle, no DONE, RESULT keeps the previous value, STALL low. A new START is then accepted normally.
- RESET asserted mid-CALC: all outputs at reset values next cycle. RESET held with START high: never accepted.
- Two back-to-back DIVU ops (100/7, then 9/3): RESULT 14 then 3. A START high in the DONE cycle is not accepted until IDLE. FUNCT3=000 with START high: no STALL, no DONE.
